// File: rtl/uart_rx_monitor_if.sv
//==============================================================================
// Module   : uart_rx_monitor_if
// Brief    : Byte stream leaving the UART receive monitor (valid/ready/payload).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface uart_rx_monitor_if;
    logic       valid;
    logic       ready;
    logic [7:0] payload;

    modport master (output valid, output payload, input ready);
    modport slave  (input valid, input payload, output ready);
endinterface

`default_nettype wire

// File: rtl/uart_rx_monitor.sv
//==============================================================================
// Module   : uart_rx_monitor
// Brief    : 8N1 UART receiver feeding a first-word-fall-through byte FIFO,
//            with framing-error pulse and saturating overflow counter.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_rx_monitor #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  wire logic                   io_clock,
    input  wire logic                   io_sysReset,
    input  wire logic                   io_rxd,
    uart_rx_monitor_if.master           io_data,
    output logic                        io_frameError,
    output logic [15:0]                 io_overflowCount,
    output logic [$clog2(FIFO_DEPTH):0] io_fifoLevel
);

    localparam int C_AW = $clog2(FIFO_DEPTH);
    localparam int C_CW = $clog2(CLKS_PER_BIT);

    localparam logic [C_CW-1:0] C_HALF_LAST  = C_CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [C_CW-1:0] C_BIT_LAST   = C_CW'(CLKS_PER_BIT - 1);
    localparam logic [C_CW-1:0] C_ARM_SETTLE = C_CW'(2);
    localparam logic [C_AW:0]   C_FULL       = (C_AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_ARM   = 3'd0,
        ST_IDLE  = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4
    } state_t;

    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    state_t          state_q, state_d;
    logic [C_CW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            push_q, push_d;
    logic            ferr_q, ferr_d;
    logic            frame_error_q, frame_error_d;
    logic [C_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [C_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [C_AW:0]   level_q, level_d;
    logic [15:0]     ovf_q, ovf_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [7:0]      mem_d [FIFO_DEPTH];

    logic w_rxs;
    logic w_full;
    logic w_pop;
    logic w_wr;
    logic w_drop;

    assign w_rxs  = sync2_q;
    assign w_full = (level_q == C_FULL);
    assign w_pop  = (level_q != '0) && io_data.ready;
    assign w_wr   = push_q && (!w_full || w_pop);
    assign w_drop = push_q && w_full && !w_pop;

    // Receive state machine; push/ferr are strobes consumed one cycle later.
    always_comb begin
        sync1_d       = io_rxd;
        sync2_d       = sync1_q;
        state_d       = state_q;
        cnt_d         = cnt_q + 1'b1;
        idx_d         = idx_q;
        shift_d       = shift_q;
        push_d        = 1'b0;
        ferr_d        = 1'b0;
        frame_error_d = ferr_q;

        case (state_q)
            ST_ARM: begin
                // The reset value of the synchronizer is not a real line
                // sample, so leave ARM only once live samples have arrived.
                if (cnt_q == C_ARM_SETTLE) begin
                    cnt_d = cnt_q;
                    if (w_rxs) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            ST_IDLE: begin
                cnt_d = '0;
                if (!w_rxs) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q == C_HALF_LAST) begin
                    cnt_d = '0;
                    idx_d = 3'd0;
                    state_d = w_rxs ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt_q == C_BIT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = w_rxs;
                    idx_d          = idx_q + 1'b1;
                    if (idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (cnt_q == C_BIT_LAST) begin
                    cnt_d = '0;
                    if (w_rxs) begin
                        push_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_ARM;
                    end
                end
            end
            default: begin
                state_d = ST_ARM;
                cnt_d   = '0;
            end
        endcase
    end

    // FIFO bookkeeping; a push into a full FIFO survives only alongside a pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        mem_d    = mem_q;

        if (w_wr) begin
            mem_d[wr_ptr_q] = shift_q;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (w_wr && !w_pop) begin
            level_d = level_q + 1'b1;
        end else if (!w_wr && w_pop) begin
            level_d = level_q - 1'b1;
        end
        if (w_drop && (ovf_q != 16'hFFFF)) begin
            ovf_d = ovf_q + 16'd1;
        end
    end

    always_ff @(posedge io_clock) begin
        if (io_sysReset) begin
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            state_q       <= ST_ARM;
            cnt_q         <= '0;
            idx_q         <= 3'd0;
            shift_q       <= 8'h00;
            push_q        <= 1'b0;
            ferr_q        <= 1'b0;
            frame_error_q <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            ovf_q         <= 16'd0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shift_q       <= shift_d;
            push_q        <= push_d;
            ferr_q        <= ferr_d;
            frame_error_q <= frame_error_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            ovf_q         <= ovf_d;
        end
    end

    // Storage needs no reset: the payload is masked whenever the FIFO is empty.
    always_ff @(posedge io_clock) begin
        mem_q <= mem_d;
    end

    assign io_data.valid    = (level_q != '0);
    assign io_data.payload  = (level_q != '0) ? mem_q[rd_ptr_q] : 8'h00;
    assign io_frameError    = frame_error_q;
    assign io_overflowCount = ovf_q;
    assign io_fifoLevel     = level_q;

endmodule

`default_nettype wire
